ip_packet_rx: RTL and testbench
===============================

# ip_packet_rx

Receive-side counterpart of the accelerator's IP transmit path. Accepts an Ethernet/IPv4 frame one byte per beat over an AXI-Stream slave interface from the MAC, and validates the Ethernet and IP headers. It extracts the 10-bit accelerator message and the sender's MAC/IP addresses. Accepted frames are presented to the accelerator core through a valid/ready handshake; rejected frames are drained and counted as drops.

## Interface
- AXI_S_DATA_WIDTH, 8, stream byte width (only 8 supported)
- IP_ADDR_WIDTH, 32, IPv4 address width
- MAC_ADDR_WIDTH, 48, MAC address width
- ACCEL_DATA_WIDTH, 10, message width
- ACLK  in  1  single clock; all logic on rising edge
- ARESET  in  1  reset, synchronous, active-high
- ACCELERATOR_IP_ADDRESS  in  [0:31]  own IP, byte 0 = bits [0:7] = first byte on wire
- ACCELERATOR_MAC_ADDRESS  in  [0:47]  own MAC, same byte order
- MAC_DATA_IN  in  [7:0]  stream byte
- MAC_DATA_VALID  in  1  byte valid
- MAC_DATA_READY  out  1  block can accept byte
- MAC_DATA_LAST  in  1  final byte of frame
- MAC_DATA_TUSER  in  1  MAC error flag; any beat with TUSER=1 poisons the frame
- SENDER_MAC_ADDRESS  out  [0:47]  Ethernet source of accepted frame
- SENDER_IP_ADDRESS  out  [0:31]  IP source of accepted frame
- SENDER_MESSAGE  out  [0:9]  extracted message
- MESSAGE_VALID  out  1  outputs above hold a valid frame
- MESSAGE_READY  in  1  accelerator consumes message
- PACKET_DROPPED  out  1  one-cycle pulse per rejected frame

## Operation
- Beat = MAC_DATA_VALID && MAC_DATA_READY. 8-bit byte counter: increments per beat, cleared on state change; saturates at 255.
- States: RECV_ETH_HDR (idle/first byte), RECV_IP_HDR, RECV_USER_DATA, DRAIN, HOLD_RESULT.
- RECV_ETH_HDR, bytes 0-13: 0-5 dest MAC, must equal ACCELERATOR_MAC_ADDRESS or FF:FF:FF:FF:FF:FF; 6-11 captured into SENDER_MAC_ADDRESS shadow; 12-13 must be 0x08, 0x00. After byte 13 -> RECV_IP_HDR.
- RECV_IP_HDR, bytes 0-19: byte 0 must be 0x45; bytes 12-15 captured as sender IP; 16-19 must equal ACCELERATOR_IP_ADDRESS. Header checksum: 16-bit big-endian words (byte 2k high, 2k+1 low) summed with end-around carry over all 10 words; result must be 0xFFFF. Other fields not checked. After byte 19 -> RECV_USER_DATA.
- RECV_USER_DATA: byte 0 bits [1:0] -> message[0:1] (bits [7:2] ignored); byte 1 -> message[2:9]; further bytes discarded. Accepted on LAST only if ≥2 user bytes received.
- Any check failure, TUSER=1, or LAST before the required byte count -> frame rejected. If LAST is on the failing beat -> pulse PACKET_DROPPED, go RECV_ETH_HDR; otherwise go DRAIN.
- DRAIN: READY=1, discard bytes until LAST beat, then pulse PACKET_DROPPED, go RECV_ETH_HDR.
- Valid frame LAST beat -> copy shadows to SENDER_* outputs, go HOLD_RESULT.
- HOLD_RESULT: MESSAGE_VALID=1, MAC_DATA_READY=0 (MAC back-pressured); outputs stable. MESSAGE_VALID && MESSAGE_READY -> RECV_ETH_HDR.
- Shadow registers never alter SENDER_* outputs outside the accept transfer.

## Timing
- Reset values: MAC_DATA_READY=0, MESSAGE_VALID=0, PACKET_DROPPED=0, SENDER_*=0, state RECV_ETH_HDR, counter 0, checksum accumulator 0, error flag 0.
- First cycle after ARESET deasserts: MAC_DATA_READY=1.
- MAC_DATA_READY is registered-state decode: 1 in all states except HOLD_RESULT.
- MESSAGE_VALID rises the cycle after the accepted LAST beat (1-cycle latency).
- After the MESSAGE_READY handshake, MAC_DATA_READY=1 the next cycle; back-to-back frame throughput is limited only by the accelerator handshake.
- PACKET_DROPPED high exactly the cycle after the rejecting LAST beat.
- VALID low mid-frame: state and counter hold; no timeout.
- ARESET mid-frame or during HOLD_RESULT: partial frame and pending message discarded, no drop pulse; the next beat is treated as Ethernet byte 0.

## Test plan
- Frame as produced by the transmit path (dst MAC = own, type 0x0800, IP 0x45, length 46, TTL 0x80, correct checksum, dst IP = own, message 0x2A5, 26 user bytes, LAST on byte 25) -> MESSAGE_VALID cycle after LAST, SENDER_MESSAGE=0x2A5, sender MAC/IP match header.
- Same frame with MESSAGE_READY held low 10 cycles, then a second frame queued -> MAC_DATA_READY=0 for those cycles, first message stable, second accepted after handshake.
- Frames with a wrong dst IP, a wrong ethertype 0x0806, or a corrupted checksum byte -> no MESSAGE_VALID; one PACKET_DROPPED pulse each, after LAST.
- Broadcast dst MAC FF:FF:FF:FF:FF:FF with a valid IP -> accepted.
- TUSER=1 on user byte 5, or LAST on IP byte 10 -> dropped, next valid frame accepted normally.
- ARESET pulsed at IP byte 7 -> READY=0 during reset, no outputs; a fresh valid frame after reset is accepted.

Source files
------------

// File: rtl/ip_packet_rx_if.sv
// ip_packet_rx_if: byte-wide AXI-Stream link from the MAC to the IP receive path.
//   MAC_DATA_IN     stream byte (first wire byte first)
//   MAC_DATA_VALID  byte valid
//   MAC_DATA_READY  receiver can accept the byte
//   MAC_DATA_LAST   final byte of the frame
//   MAC_DATA_TUSER  MAC error flag; poisons the whole frame
// Modports: master = MAC side, slave = receiver side.
interface ip_packet_rx_if #(
  parameter int AXI_S_DATA_WIDTH = 8
) ();
  logic [AXI_S_DATA_WIDTH-1:0] MAC_DATA_IN;
  logic                        MAC_DATA_VALID;
  logic                        MAC_DATA_READY;
  logic                        MAC_DATA_LAST;
  logic                        MAC_DATA_TUSER;

  modport master (
    output MAC_DATA_IN, MAC_DATA_VALID, MAC_DATA_LAST, MAC_DATA_TUSER,
    input  MAC_DATA_READY
  );

  modport slave (
    input  MAC_DATA_IN, MAC_DATA_VALID, MAC_DATA_LAST, MAC_DATA_TUSER,
    output MAC_DATA_READY
  );
endinterface

// File: rtl/ip_packet_rx.sv
// ip_packet_rx: receives an Ethernet/IPv4 frame one byte per beat, validates the
// Ethernet and IPv4 headers, extracts a 10-bit accelerator message plus the
// sender MAC/IP, and hands accepted frames to the accelerator core. Rejected
// frames are drained and reported with a one-cycle PACKET_DROPPED pulse.
// Ports:
//   ACLK, ARESET                 clock, synchronous active-high reset
//   ACCELERATOR_IP/MAC_ADDRESS   own addresses, bit 0 = MSB of first wire byte
//   s_mac                        byte stream from the MAC (slave modport)
//   SENDER_MAC/IP_ADDRESS        source addresses of the accepted frame
//   SENDER_MESSAGE               extracted message
//   MESSAGE_VALID/READY          handshake towards the accelerator core
//   PACKET_DROPPED               pulse, one per rejected frame
//
// state          | meaning
// RECV_ETH_HDR   | idle / Ethernet header bytes 0-13
// RECV_IP_HDR    | IPv4 header bytes 0-19, checksum accumulation
// RECV_USER_DATA | message bytes 0-1, remaining payload discarded
// DRAIN          | frame already rejected, swallow bytes until LAST
// HOLD_RESULT    | message presented, MAC back-pressured until consumed
module ip_packet_rx #(
  parameter int AXI_S_DATA_WIDTH = 8,
  parameter int IP_ADDR_WIDTH    = 32,
  parameter int MAC_ADDR_WIDTH   = 48,
  parameter int ACCEL_DATA_WIDTH = 10
) (
  input  logic                        ACLK,
  input  logic                        ARESET,
  input  logic [0:IP_ADDR_WIDTH-1]    ACCELERATOR_IP_ADDRESS,
  input  logic [0:MAC_ADDR_WIDTH-1]   ACCELERATOR_MAC_ADDRESS,
  ip_packet_rx_if.slave               s_mac,
  output logic [0:MAC_ADDR_WIDTH-1]   SENDER_MAC_ADDRESS,
  output logic [0:IP_ADDR_WIDTH-1]    SENDER_IP_ADDRESS,
  output logic [0:ACCEL_DATA_WIDTH-1] SENDER_MESSAGE,
  output logic                        MESSAGE_VALID,
  input  logic                        MESSAGE_READY,
  output logic                        PACKET_DROPPED
);

  typedef enum logic [2:0] {
    RECV_ETH_HDR,
    RECV_IP_HDR,
    RECV_USER_DATA,
    DRAIN,
    HOLD_RESULT
  } state_t;

  state_t                      r_state;
  logic [7:0]                  r_cnt;
  logic                        r_ready;
  logic                        r_valid;
  logic                        r_drop;
  logic                        r_own_ok;
  logic                        r_bc_ok;
  logic [15:0]                 r_csum;
  logic [7:0]                  r_csum_hi;
  logic [0:MAC_ADDR_WIDTH-1]   r_sh_mac;
  logic [0:IP_ADDR_WIDTH-1]    r_sh_ip;
  logic [1:0]                  r_msg_hi;
  logic [7:0]                  r_msg_lo;
  logic [0:MAC_ADDR_WIDTH-1]   r_out_mac;
  logic [0:IP_ADDR_WIDTH-1]    r_out_ip;
  logic [0:ACCEL_DATA_WIDTH-1] r_out_msg;

  logic [AXI_S_DATA_WIDTH-1:0] w_byte;
  logic                        w_beat;
  logic                        w_last;
  logic                        w_own_ok;
  logic                        w_bc_ok;
  logic [16:0]                 w_sum17;
  logic [15:0]                 w_csum_next;
  logic                        w_fail;
  logic                        w_hdr_done;
  logic                        w_enough;
  logic                        w_in_frame;
  logic                        w_bad;
  logic                        w_accept;
  logic [7:0]                  w_cnt_inc;
  logic [0:ACCEL_DATA_WIDTH-1] w_msg_next;

  function automatic logic [7:0] mac_byte(input logic [0:47] mac, input logic [2:0] idx);
    case (idx)
      3'd0:    mac_byte = mac[0:7];
      3'd1:    mac_byte = mac[8:15];
      3'd2:    mac_byte = mac[16:23];
      3'd3:    mac_byte = mac[24:31];
      3'd4:    mac_byte = mac[32:39];
      3'd5:    mac_byte = mac[40:47];
      default: mac_byte = 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] ip_byte(input logic [0:31] ip, input logic [1:0] idx);
    case (idx)
      2'd0:    ip_byte = ip[0:7];
      2'd1:    ip_byte = ip[8:15];
      2'd2:    ip_byte = ip[16:23];
      default: ip_byte = ip[24:31];
    endcase
  endfunction

  assign s_mac.MAC_DATA_READY = r_ready;
  assign SENDER_MAC_ADDRESS   = r_out_mac;
  assign SENDER_IP_ADDRESS    = r_out_ip;
  assign SENDER_MESSAGE       = r_out_msg;
  assign MESSAGE_VALID        = r_valid;
  assign PACKET_DROPPED       = r_drop;

  always_comb begin
    w_byte      = s_mac.MAC_DATA_IN;
    w_last      = s_mac.MAC_DATA_LAST;
    w_beat      = s_mac.MAC_DATA_VALID && r_ready;
    w_cnt_inc   = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
    // Destination MAC may match either own address or broadcast; both
    // candidates are tracked byte by byte and the frame fails once neither holds.
    w_own_ok    = ((r_cnt == 8'd0) || r_own_ok) &&
                  (w_byte == mac_byte(ACCELERATOR_MAC_ADDRESS, r_cnt[2:0]));
    w_bc_ok     = ((r_cnt == 8'd0) || r_bc_ok) && (w_byte == 8'hFF);
    // Ones-complement accumulate of the big-endian word {previous byte, this byte}.
    w_sum17     = {1'b0, r_csum} + {1'b0, r_csum_hi, w_byte};
    w_csum_next = w_sum17[15:0] + {15'd0, w_sum17[16]};
    w_msg_next  = (r_cnt == 8'd1) ? {r_msg_hi, w_byte} : {r_msg_hi, r_msg_lo};
    w_fail      = 1'b0;
    w_hdr_done  = 1'b0;
    w_enough    = 1'b0;
    w_in_frame  = 1'b0;
    case (r_state)
      RECV_ETH_HDR: begin
        w_in_frame = 1'b1;
        if ((r_cnt < 8'd6) && !(w_own_ok || w_bc_ok)) w_fail = 1'b1;
        if ((r_cnt == 8'd12) && (w_byte != 8'h08))    w_fail = 1'b1;
        if ((r_cnt == 8'd13) && (w_byte != 8'h00))    w_fail = 1'b1;
        w_hdr_done = (r_cnt == 8'd13);
      end
      RECV_IP_HDR: begin
        w_in_frame = 1'b1;
        if ((r_cnt == 8'd0) && (w_byte != 8'h45)) w_fail = 1'b1;
        if ((r_cnt >= 8'd16) && (r_cnt <= 8'd19) &&
            (w_byte != ip_byte(ACCELERATOR_IP_ADDRESS, r_cnt[1:0]))) w_fail = 1'b1;
        if ((r_cnt == 8'd19) && (w_csum_next != 16'hFFFF)) w_fail = 1'b1;
        w_hdr_done = (r_cnt == 8'd19);
      end
      RECV_USER_DATA: begin
        w_in_frame = 1'b1;
        w_enough   = (r_cnt >= 8'd1);
      end
      default: ;
    endcase
    // LAST is only legal in the user-data phase once both message bytes arrived.
    w_bad    = w_in_frame && (w_fail || s_mac.MAC_DATA_TUSER || (w_last && !w_enough));
    w_accept = (r_state == RECV_USER_DATA) && w_last && !w_bad;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state   <= RECV_ETH_HDR;
      r_cnt     <= '0;
      r_ready   <= 1'b0;
      r_valid   <= 1'b0;
      r_drop    <= 1'b0;
      r_own_ok  <= 1'b0;
      r_bc_ok   <= 1'b0;
      r_csum    <= '0;
      r_csum_hi <= '0;
      r_sh_mac  <= '0;
      r_sh_ip   <= '0;
      r_msg_hi  <= '0;
      r_msg_lo  <= '0;
      r_out_mac <= '0;
      r_out_ip  <= '0;
      r_out_msg <= '0;
    end else begin
      r_drop  <= 1'b0;
      r_ready <= 1'b1;
      case (r_state)
        RECV_ETH_HDR, RECV_IP_HDR, RECV_USER_DATA: begin
          if (w_beat) begin
            case (r_state)
              RECV_ETH_HDR: begin
                r_own_ok <= w_own_ok;
                r_bc_ok  <= w_bc_ok;
                if ((r_cnt >= 8'd6) && (r_cnt <= 8'd11))
                  r_sh_mac <= {r_sh_mac[8:MAC_ADDR_WIDTH-1], w_byte};
              end
              RECV_IP_HDR: begin
                if ((r_cnt >= 8'd12) && (r_cnt <= 8'd15))
                  r_sh_ip <= {r_sh_ip[8:IP_ADDR_WIDTH-1], w_byte};
                if (!r_cnt[0]) r_csum_hi <= w_byte;
                else           r_csum    <= w_csum_next;
              end
              default: begin
                if (r_cnt == 8'd0) r_msg_hi <= w_byte[1:0];
                if (r_cnt == 8'd1) r_msg_lo <= w_byte;
              end
            endcase

            if (w_bad) begin
              r_cnt <= '0;
              if (w_last) begin
                r_drop  <= 1'b1;
                r_state <= RECV_ETH_HDR;
              end else begin
                r_state <= DRAIN;
              end
            end else if (w_accept) begin
              r_out_mac <= r_sh_mac;
              r_out_ip  <= r_sh_ip;
              r_out_msg <= w_msg_next;
              r_valid   <= 1'b1;
              r_ready   <= 1'b0;
              r_cnt     <= '0;
              r_state   <= HOLD_RESULT;
            end else if (w_hdr_done) begin
              r_cnt <= '0;
              if (r_state == RECV_ETH_HDR) begin
                r_csum    <= '0;
                r_csum_hi <= '0;
                r_state   <= RECV_IP_HDR;
              end else begin
                r_state <= RECV_USER_DATA;
              end
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
        end
        DRAIN: begin
          if (w_beat) begin
            if (w_last) begin
              r_drop  <= 1'b1;
              r_cnt   <= '0;
              r_state <= RECV_ETH_HDR;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
        end
        HOLD_RESULT: begin
          if (MESSAGE_READY) begin
            r_valid <= 1'b0;
            r_state <= RECV_ETH_HDR;
          end else begin
            r_ready <= 1'b0;
          end
        end
        default: r_state <= RECV_ETH_HDR;
      endcase
    end
  end

endmodule

// File: tb/tb_ip_packet_rx.sv
// tb_ip_packet_rx: frame-level bench for ip_packet_rx. Frames are built with a
// computed IPv4 checksum; the expected outcome of each frame is queued when it
// is sent and retired when the DUT presents a message or a drop pulse.
module tb_ip_packet_rx;
  localparam logic [47:0] OWN_MAC = 48'h02_1A_2B_3C_4D_5E;
  localparam logic [31:0] OWN_IP  = 32'hC0_A8_01_64;
  localparam logic [47:0] BCAST   = 48'hFF_FF_FF_FF_FF_FF;
  localparam int          FULL    = 59;

  typedef struct {
    bit          drop;
    logic [47:0] mac;
    logic [31:0] ip;
    logic [9:0]  msg;
  } exp_t;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic [0:31] acc_ip;
  logic [0:47] acc_mac;
  logic [0:47] snd_mac;
  logic [0:31] snd_ip;
  logic [0:9]  snd_msg;
  logic        msg_valid;
  logic        msg_ready = 1'b0;
  logic        pkt_drop;

  assign acc_ip  = OWN_IP;
  assign acc_mac = OWN_MAC;

  ip_packet_rx_if mac_if ();

  ip_packet_rx dut (
    .ACLK                    (ACLK),
    .ARESET                  (ARESET),
    .ACCELERATOR_IP_ADDRESS  (acc_ip),
    .ACCELERATOR_MAC_ADDRESS (acc_mac),
    .s_mac                   (mac_if),
    .SENDER_MAC_ADDRESS      (snd_mac),
    .SENDER_IP_ADDRESS       (snd_ip),
    .SENDER_MESSAGE          (snd_msg),
    .MESSAGE_VALID           (msg_valid),
    .MESSAGE_READY           (msg_ready),
    .PACKET_DROPPED          (pkt_drop)
  );

  always #5 ACLK = ~ACLK;

  int         n_vec = 0;
  int         n_err = 0;
  int         stall_cycles = 0;
  int         stall_cnt = 0;
  bit         hs_prev = 1'b0;
  exp_t       sb[$];
  logic [7:0] frm[$];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t mk(input bit drop, input logic [47:0] mac,
                              input logic [31:0] ip, input logic [9:0] msg);
    exp_t e;
    e.drop = drop;
    e.mac  = mac;
    e.ip   = ip;
    e.msg  = msg;
    return e;
  endfunction

  task automatic build_frame(input logic [47:0] dmac, input logic [15:0] etype,
                             input logic [47:0] smac, input logic [31:0] sip,
                             input logic [31:0] dip, input logic [9:0] msg,
                             input int n_user, input bit bad_csum);
    logic [7:0]  hdr[20];
    logic [31:0] s;
    logic [15:0] cs;
    frm.delete();
    for (int i = 0; i < 6; i++) frm.push_back(dmac[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) frm.push_back(smac[47-8*i -: 8]);
    frm.push_back(etype[15:8]);
    frm.push_back(etype[7:0]);
    for (int i = 0; i < 20; i++) hdr[i] = 8'h00;
    hdr[0] = 8'h45;
    hdr[3] = 8'(20 + n_user);
    hdr[8] = 8'h80;
    hdr[9] = 8'h11;
    for (int i = 0; i < 4; i++) begin
      hdr[12+i] = sip[31-8*i -: 8];
      hdr[16+i] = dip[31-8*i -: 8];
    end
    s = 32'd0;
    for (int k = 0; k < 10; k++) s = s + {16'h0, hdr[2*k], hdr[2*k+1]};
    while (s[31:16] != 16'h0) s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
    cs = ~s[15:0];
    hdr[10] = cs[15:8];
    hdr[11] = cs[7:0];
    if (bad_csum) hdr[11] = hdr[11] ^ 8'h04;
    for (int i = 0; i < 20; i++) frm.push_back(hdr[i]);
    for (int i = 0; i < n_user; i++) begin
      if (i == 0)      frm.push_back({6'($urandom), msg[9:8]});
      else if (i == 1) frm.push_back(msg[7:0]);
      else             frm.push_back(8'($urandom));
    end
  endtask

  task automatic drive_beat(input logic [7:0] b, input bit last, input bit tuser, input int gap);
    int guard = 0;
    @(negedge ACLK);
    if (gap > 0) begin
      mac_if.MAC_DATA_VALID = 1'b0;
      repeat ($urandom_range(0, gap)) @(negedge ACLK);
    end
    mac_if.MAC_DATA_IN    = b;
    mac_if.MAC_DATA_VALID = 1'b1;
    mac_if.MAC_DATA_LAST  = last;
    mac_if.MAC_DATA_TUSER = tuser;
    while (!mac_if.MAC_DATA_READY && guard < 100) begin
      @(negedge ACLK);
      guard++;
    end
    if (guard >= 100) check_val("ready_wait", 64'(mac_if.MAC_DATA_READY), 64'd1);
    @(posedge ACLK);
  endtask

  task automatic idle_bus();
    mac_if.MAC_DATA_VALID = 1'b0;
    mac_if.MAC_DATA_LAST  = 1'b0;
    mac_if.MAC_DATA_TUSER = 1'b0;
  endtask

  task automatic send_frame(input exp_t e, input int last_idx, input int tuser_idx, input int gap);
    sb.push_back(e);
    for (int i = 0; i <= last_idx; i++)
      drive_beat(frm[i], i == last_idx, i == tuser_idx, gap);
    @(negedge ACLK);
    idle_bus();
    check_val("valid_after_last", 64'(msg_valid), 64'(!e.drop));
    check_val("drop_after_last",  64'(pkt_drop),  64'(e.drop));
  endtask

  task automatic good_frame(input logic [47:0] dmac, input logic [47:0] smac,
                            input logic [31:0] sip, input logic [9:0] msg, input int gap);
    build_frame(dmac, 16'h0800, smac, sip, OWN_IP, msg, 26, 1'b0);
    send_frame(mk(1'b0, smac, sip, msg), FULL, -1, gap);
  endtask

  // Accelerator side: consume each message after stall_cycles extra cycles.
  initial begin
    forever begin
      @(posedge ACLK);
      #1;
      if (msg_valid && !msg_ready) begin
        if (stall_cnt < stall_cycles) stall_cnt++;
        else                          msg_ready = 1'b1;
      end else begin
        msg_ready = 1'b0;
        stall_cnt = 0;
      end
    end
  end

  // Scoreboard monitor.
  initial begin
    exp_t e;
    forever begin
      @(negedge ACLK);
      if (ARESET) begin
        hs_prev = 1'b0;
      end else begin
        if (hs_prev) check_val("ready_after_hs", 64'(mac_if.MAC_DATA_READY), 64'd1);
        hs_prev = 1'b0;
        if (pkt_drop) begin
          if (sb.size() == 0) check_val("drop_unexpected", 64'(sb.size()), 64'd1);
          else begin
            e = sb.pop_front();
            check_val("drop_expected", 64'(e.drop), 64'd1);
          end
        end
        if (msg_valid) begin
          check_val("ready_in_hold", 64'(mac_if.MAC_DATA_READY), 64'd0);
          if (sb.size() == 0) check_val("valid_unexpected", 64'(sb.size()), 64'd1);
          else begin
            e = sb[0];
            check_val("accept_expected", 64'(e.drop), 64'd0);
            check_val("sender_mac", 64'(snd_mac), 64'(e.mac));
            check_val("sender_ip",  64'(snd_ip),  64'(e.ip));
            check_val("sender_msg", 64'(snd_msg), 64'(e.msg));
            if (msg_ready) begin
              void'(sb.pop_front());
              hs_prev = 1'b1;
            end
          end
        end
      end
    end
  end

  initial begin
    int w;
    idle_bus();
    mac_if.MAC_DATA_IN = 8'h00;
    repeat (4) @(negedge ACLK);
    check_val("rst_ready",   64'(mac_if.MAC_DATA_READY), 64'd0);
    check_val("rst_valid",   64'(msg_valid), 64'd0);
    check_val("rst_drop",    64'(pkt_drop),  64'd0);
    check_val("rst_snd_mac", 64'(snd_mac),   64'd0);
    check_val("rst_snd_ip",  64'(snd_ip),    64'd0);
    check_val("rst_snd_msg", 64'(snd_msg),   64'd0);
    ARESET = 1'b0;
    @(negedge ACLK);
    check_val("ready_after_rst", 64'(mac_if.MAC_DATA_READY), 64'd1);

    // Nominal frame from the transmit path.
    good_frame(OWN_MAC, 48'h00_11_22_33_44_55, 32'hC0_A8_01_0A, 10'h2A5, 0);

    // Slow accelerator with a second frame queued behind the first.
    stall_cycles = 10;
    good_frame(OWN_MAC, 48'h00_11_22_33_44_66, 32'h0A_00_00_01, 10'h15A, 0);
    good_frame(OWN_MAC, 48'hA0_B1_C2_D3_E4_F5, 32'h0A_00_00_02, 10'h3FF, 0);
    stall_cycles = 0;

    // Rejected headers.
    build_frame(OWN_MAC, 16'h0800, 48'h00_11_22_33_44_55, 32'h01_02_03_04, 32'hC0_A8_01_65, 10'h2A5, 26, 1'b0);
    send_frame(mk(1'b1, '0, '0, '0), FULL, -1, 0);
    build_frame(OWN_MAC, 16'h0806, 48'h00_11_22_33_44_55, 32'h01_02_03_04, OWN_IP, 10'h2A5, 26, 1'b0);
    send_frame(mk(1'b1, '0, '0, '0), FULL, -1, 0);
    build_frame(OWN_MAC, 16'h0800, 48'h00_11_22_33_44_55, 32'h01_02_03_04, OWN_IP, 10'h2A5, 26, 1'b1);
    send_frame(mk(1'b1, '0, '0, '0), FULL, -1, 0);
    build_frame(48'h02_1A_2B_3C_4D_5F, 16'h0800, 48'h00_11_22_33_44_55, 32'h01_02_03_04, OWN_IP, 10'h2A5, 26, 1'b0);
    send_frame(mk(1'b1, '0, '0, '0), FULL, -1, 0);

    // Broadcast destination.
    good_frame(BCAST, 48'h12_34_56_78_9A_BC, 32'hAC_10_00_05, 10'h001, 0);

    // TUSER on user byte 5, then a clean frame.
    build_frame(OWN_MAC, 16'h0800, 48'h00_11_22_33_44_55, 32'h01_02_03_04, OWN_IP, 10'h2A5, 26, 1'b0);
    send_frame(mk(1'b1, '0, '0, '0), FULL, 39, 0);
    good_frame(OWN_MAC, 48'h00_0A_0B_0C_0D_0E, 32'h08_08_08_08, 10'h0C3, 0);

    // LAST on IP byte 10, then a clean frame.
    build_frame(OWN_MAC, 16'h0800, 48'h00_11_22_33_44_55, 32'h01_02_03_04, OWN_IP, 10'h2A5, 26, 1'b0);
    send_frame(mk(1'b1, '0, '0, '0), 24, -1, 0);
    good_frame(OWN_MAC, 48'h00_0A_0B_0C_0D_0F, 32'h08_08_04_04, 10'h21E, 0);

    // One user byte is too short; exactly two is enough.
    build_frame(OWN_MAC, 16'h0800, 48'h00_11_22_33_44_55, 32'h01_02_03_04, OWN_IP, 10'h2A5, 1, 1'b0);
    send_frame(mk(1'b1, '0, '0, '0), 34, -1, 0);
    build_frame(OWN_MAC, 16'h0800, 48'h66_55_44_33_22_11, 32'h7F_00_00_01, OWN_IP, 10'h18D, 2, 1'b0);
    send_frame(mk(1'b0, 48'h66_55_44_33_22_11, 32'h7F_00_00_01, 10'h18D), 35, -1, 0);

    // VALID gaps mid-frame.
    good_frame(OWN_MAC, 48'h00_DE_AD_BE_EF_01, 32'hC6_33_64_07, 10'h2F0, 3);

    // Reset at IP byte 7, then a fresh frame.
    build_frame(OWN_MAC, 16'h0800, 48'h00_11_22_33_44_55, 32'h01_02_03_04, OWN_IP, 10'h2A5, 26, 1'b0);
    for (int i = 0; i <= 21; i++) drive_beat(frm[i], 1'b0, 1'b0, 0);
    @(negedge ACLK);
    idle_bus();
    ARESET = 1'b1;
    repeat (3) begin
      @(negedge ACLK);
      check_val("midrst_ready", 64'(mac_if.MAC_DATA_READY), 64'd0);
      check_val("midrst_valid", 64'(msg_valid), 64'd0);
      check_val("midrst_drop",  64'(pkt_drop),  64'd0);
    end
    check_val("midrst_snd_msg", 64'(snd_msg), 64'd0);
    ARESET = 1'b0;
    @(negedge ACLK);
    check_val("ready_after_midrst", 64'(mac_if.MAC_DATA_READY), 64'd1);
    good_frame(OWN_MAC, 48'h00_11_22_33_44_77, 32'hC0_A8_01_0B, 10'h2A5, 0);

    w = 0;
    while (sb.size() != 0 && w < 200) begin
      @(negedge ACLK);
      w++;
    end
    check_val("sb_drained", 64'(sb.size()), 64'd0);
    repeat (3) @(negedge ACLK);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
